// File: rtl/key_led_mode.sv
// key_led_mode: four active-low push-buttons select an LED pattern mode.
// Each key is synchronized and debounced. A debounced press (1->0) toggles
// its mapped mode on or back to OFF. A free-running step counter then
// animates the LEDs in the selected mode.
module key_led_mode #(
  parameter int LED_W    = 4,
  parameter int STEP_CNT = 10_000_000,
  parameter int DEB_CNT  = 1_000_000
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [3:0]       key,
  output logic [LED_W-1:0] led,
  output logic [2:0]       mode
);

  localparam logic [2:0] MODE_OFF     = 3'd0;
  localparam logic [2:0] MODE_WALK_DN = 3'd1;
  localparam logic [2:0] MODE_WALK_UP = 3'd2;
  localparam logic [2:0] MODE_BLINK   = 3'd3;
  localparam logic [2:0] MODE_ALL_ON  = 3'd4;

  localparam int STEP_W = (STEP_CNT > 2) ? $clog2(STEP_CNT) : 1;
  localparam int DEB_W  = (DEB_CNT > 2) ? $clog2(DEB_CNT) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CNT - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CNT - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);

  // Key input conditioning state
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       stable;
  logic [3:0]       stable_prev;
  logic [DEB_W-1:0] deb_cnt [4];
  logic [3:0]       press;
  logic [3:0]       armed;
  logic [1:0]       fill_cnt;

  // Pattern engine state
  logic [STEP_W-1:0] step_cnt;
  logic              step_tick;
  logic              win_valid;
  logic [2:0]        win_mode;
  logic [2:0]        target_mode;

  // Initial LED pattern loaded whenever a mode is entered.
  function automatic logic [LED_W-1:0] init_pattern(input logic [2:0] m);
    logic [LED_W-1:0] p;
    p = '0;
    case (m)
      MODE_WALK_DN: p[LED_W-1] = 1'b1;
      MODE_WALK_UP: p[0]       = 1'b1;
      MODE_BLINK:   p          = '1;
      MODE_ALL_ON:  p          = '1;
      default:      p          = '0;
    endcase
    return p;
  endfunction

  // Mode selected by each key index.
  function automatic logic [2:0] key_mode(input int idx);
    logic [2:0] m;
    case (idx)
      0:       m = MODE_WALK_DN;
      1:       m = MODE_WALK_UP;
      2:       m = MODE_BLINK;
      default: m = MODE_ALL_ON;
    endcase
    return m;
  endfunction

  // Two-flop synchronizer; released (1) is the reset level.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  // Per-key debounce: accept a new level after DEB_CNT consecutive differing cycles.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      stable <= 4'hF;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != stable[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            stable[i]  <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_ONE;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Arming: a key seen held low once the synchronizer has refilled after
  // reset stays disarmed until it is released, so a key held through reset
  // does not re-trigger. Keys pressed later arm normally and keep the full
  // sync plus debounce latency.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      fill_cnt <= 2'd0;
      armed    <= 4'h0;
    end else begin
      if (fill_cnt != 2'd3) fill_cnt <= fill_cnt + 2'd1;
      if (fill_cnt == 2'd2) armed <= sync2;
      else                  armed <= armed | (stable & ~stable_prev);
    end
  end

  // Registered one-cycle press pulse on a debounced 1->0 edge of an armed key.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      stable_prev <= 4'hF;
      press       <= 4'h0;
    end else begin
      stable_prev <= stable;
      press       <= armed & stable_prev & ~stable;
    end
  end

  // Lowest key index wins among simultaneous presses; the rest are dropped.
  always_comb begin
    win_valid = 1'b0;
    win_mode  = MODE_OFF;
    for (int i = 3; i >= 0; i--) begin
      if (press[i]) begin
        win_valid = 1'b1;
        win_mode  = key_mode(i);
      end
    end
    target_mode = (mode == win_mode) ? MODE_OFF : win_mode;
  end

  assign step_tick = (step_cnt == STEP_LAST);

  // Mode register, step counter and LED pattern; a mode change beats a tick.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      mode     <= MODE_OFF;
      led      <= '0;
      step_cnt <= '0;
    end else if (mode > MODE_ALL_ON) begin
      mode     <= MODE_OFF;
      led      <= '0;
      step_cnt <= '0;
    end else if (win_valid) begin
      mode     <= target_mode;
      led      <= init_pattern(target_mode);
      step_cnt <= '0;
    end else begin
      step_cnt <= step_tick ? '0 : step_cnt + STEP_ONE;
      if (step_tick) begin
        case (mode)
          MODE_WALK_DN: led <= {led[0], led[LED_W-1:1]};
          MODE_WALK_UP: led <= {led[LED_W-2:0], led[LED_W-1]};
          MODE_BLINK:   led <= ~led;
          default:      led <= led;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_led_mode.sv
// Directed bench for key_led_mode with LED_W=4, STEP_CNT=4, DEB_CNT=3.
// Expected {mode, led} words are queued as stimulus is driven and popped
// when the DUT output is sampled on the falling clock edge.
module tb_key_led_mode;

  logic       sys_clk;
  logic       rst;
  logic [3:0] key;
  logic [3:0] led;
  logic [2:0] mode;

  int checks = 0;
  int errors = 0;

  logic [6:0] exp_q[$];

  // Model state: current expected mode and cycles since it was entered.
  logic [2:0] cur_mode;
  int         t_chg;

  key_led_mode #(
    .LED_W   (4),
    .STEP_CNT(4),
    .DEB_CNT (3)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .key    (key),
    .led    (led),
    .mode   (mode)
  );

  // Clock
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Expected {mode, led} t cycles after entering mode m (one step per 4 cycles).
  function automatic logic [6:0] exp_pat(input logic [2:0] m, input int t);
    int         s;
    logic [3:0] p;
    s = t / 4;
    case (m)
      3'd1:    p = 4'b1000 >> (s % 4);
      3'd2:    p = 4'b0001 << (s % 4);
      3'd3:    p = ((s % 2) == 1) ? 4'b0000 : 4'b1111;
      3'd4:    p = 4'b1111;
      default: p = 4'b0000;
    endcase
    return {m, p};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
    t_chg += n;
  endtask

  task automatic check(input string tag);
    logic [6:0] e;
    logic [6:0] o;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s observed=%b expected=<empty queue>", tag, {mode, led});
      return;
    end
    e = exp_q.pop_front();
    o = {mode, led};
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed mode=%0d led=%b expected mode=%0d led=%b",
             tag, o[6:4], o[3:0], e[6:4], e[3:0]);
    end
  endtask

  task automatic check_state(input string tag);
    exp_q.push_back(exp_pat(cur_mode, t_chg));
    check(tag);
  endtask

  // Press keys in mask and hold them; the mode changes 7 cycles later.
  task automatic press_key(input logic [3:0] mask, input logic [2:0] new_mode,
                           input string tag);
    key = key & ~mask;
    exp_q.push_back(exp_pat(cur_mode, t_chg + 6));
    exp_q.push_back(exp_pat(new_mode, 0));
    wait_cyc(6);
    check({tag, "_pre"});
    wait_cyc(1);
    cur_mode = new_mode;
    t_chg    = 0;
    check({tag, "_post"});
  endtask

  task automatic release_key(input logic [3:0] mask);
    key = key | mask;
    wait_cyc(10);
  endtask

  initial begin
    rst      = 1'b1;
    key      = 4'hF;
    cur_mode = 3'd0;
    t_chg    = 0;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    check_state("reset");
    wait_cyc(4);
    check_state("idle");

    // key0 held: WALK_DN, walking right every 4 cycles
    press_key(4'b0001, 3'd1, "k0");
    for (int i = 0; i < 4; i++) begin
      wait_cyc(4);
      check_state("walk_dn");
    end
    release_key(4'b0001);
    check_state("k0_release");

    // 2-cycle glitch on key1 is rejected
    key[1] = 1'b0;
    wait_cyc(2);
    key[1] = 1'b1;
    wait_cyc(10);
    check_state("glitch");

    // key1 held: WALK_UP, walking left
    press_key(4'b0010, 3'd2, "k1");
    for (int i = 0; i < 4; i++) begin
      wait_cyc(4);
      check_state("walk_up");
    end

    // Reset for one cycle with key1 still held
    wait_cyc(1);
    rst = 1'b1;
    @(negedge sys_clk);
    rst      = 1'b0;
    cur_mode = 3'd0;
    t_chg    = 0;
    check_state("mid_reset");
    wait_cyc(20);
    check_state("held_no_retrigger");
    release_key(4'b0010);
    check_state("after_release");
    press_key(4'b0010, 3'd2, "k1_again");
    release_key(4'b0010);
    wait_cyc(2);
    check_state("walk_up_run");

    // key0 and key2 together: key0 wins
    press_key(4'b0101, 3'd1, "k0_k2");

    // key1 press lands on a step tick: initial pattern wins
    wait_cyc(1);
    press_key(4'b0010, 3'd2, "tick_collide");
    wait_cyc(3);
    check_state("collide_hold");
    wait_cyc(1);
    check_state("collide_step");
    release_key(4'b0111);
    check_state("collide_release");

    // BLINK, then key2 again -> OFF, then key3 -> ALL_ON
    press_key(4'b0100, 3'd3, "k2_blink");
    wait_cyc(4);
    check_state("blink_1");
    wait_cyc(4);
    check_state("blink_2");
    release_key(4'b0100);
    press_key(4'b0100, 3'd0, "k2_off");
    release_key(4'b0100);
    wait_cyc(10);
    check_state("off_hold");
    press_key(4'b1000, 3'd4, "k3_all_on");
    wait_cyc(20);
    check_state("all_on_hold");
    release_key(4'b1000);
    check_state("all_on_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
